// File: rtl/fib_timer_gen.sv
// -----------------------------------------------------------------------------
// fib_timer_gen
//
// Single counting engine with two modes: a Fibonacci sequence generator and a
// modulo up-timer. A programmable prescaler sets the step period. The speed
// code is loaded through a one-cycle update strobe. The block sits between the
// push-button/switch synchronisers and the 7-segment display driver.
//
// Step period P = DIV_BASE << speed_reg clock cycles.
//
// Parameters
//   WIDTH     : width of count and of the Fibonacci state registers
//   PROG_W    : width of the speed code prog
//   DIV_BASE  : base prescaler period in clock cycles (>= 1)
//   TIMER_MAX : last timer value before the timer wraps (< 2**WIDTH)
//
// Ports
//   clk      in   1       system clock, all logic on the rising edge
//   rst      in   1       synchronous reset, active low
//   update   in   1       strobe: load prog into the speed register
//   prog     in   PROG_W  speed code, sampled only while update = 1
//   start_f  in   1       strobe: (re)start Fibonacci mode
//   start_t  in   1       strobe: (re)start timer mode
//   stop     in   1       strobe: halt counting, hold count
//   count    out  WIDTH   current sequence value
//   mode     out  2       00 idle, 01 Fibonacci, 10 timer (the FSM state)
//   tick     out  1       pulse in the cycle count takes a new stepped value
//   ovf      out  1       pulse in the cycle a wrap/restart occurs
//   parity   out  1       even parity of count
//
// Strobe protocol: every command input is a single-cycle strobe sampled on the
// rising edge. There is no ready/acknowledge. A strobe is acted on in the
// cycle it is seen. Within one cycle stop wins over start_f, and start_f wins
// over start_t. update is independent of the command strobes.
//
// Optional feature macro: FIB_PARITY_EN
//   defined   : parity is the XOR-reduction of the next count, registered
//               together with count
//   undefined : parity is tied to 0 and no parity logic exists
//
// All outputs are registered. There is no combinational input-to-output path.
// -----------------------------------------------------------------------------
module fib_timer_gen #(
    parameter int WIDTH     = 16,
    parameter int PROG_W    = 3,
    parameter int DIV_BASE  = 2,
    parameter int TIMER_MAX = 9999
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              update,
    input  logic [PROG_W-1:0] prog,
    input  logic              start_f,
    input  logic              start_t,
    input  logic              stop,
    output logic [WIDTH-1:0]  count,
    output logic [1:0]        mode,
    output logic              tick,
    output logic              ovf,
    output logic              parity
);

    // -------------------------------------------------------------------------
    // Types and constants
    // -------------------------------------------------------------------------
    // The state encoding is the mode output encoding, so mode is the state
    // register itself and is directly visible for checking.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FIB  = 2'b01,
        ST_TMR  = 2'b10
    } state_t;

    // The prescaler must hold DIV_BASE shifted left by the largest speed code,
    // which is (2**PROG_W - 1). One spare bit keeps the width safe for any
    // DIV_BASE.
    localparam int PRE_W = $clog2(DIV_BASE + 1) + (1 << PROG_W);

    localparam logic [WIDTH-1:0] TMAX     = WIDTH'(TIMER_MAX);
    localparam logic [PRE_W-1:0] PRE_BASE = PRE_W'(DIV_BASE);

    // -------------------------------------------------------------------------
    // Registers and their next-state values
    // -------------------------------------------------------------------------
    state_t              state,     state_nxt;
    logic [PROG_W-1:0]   speed_reg, speed_nxt;
    logic [PRE_W-1:0]    pre,       pre_nxt;
    logic [WIDTH-1:0]    fib_a,     fib_a_nxt;
    // fib_b is one bit wider than count. Its top bit records that the
    // previous addition overflowed. The value that overflowed is never shown.
    // Instead, the step that would have shown it restarts the sequence. This
    // makes the largest representable Fibonacci number appear as a value of
    // count before the restart.
    logic [WIDTH:0]      fib_b,     fib_b_nxt;
    logic [WIDTH-1:0]    count_q,   count_nxt;
    logic                tick_q,    tick_nxt;
    logic                ovf_q,     ovf_nxt;

    // -------------------------------------------------------------------------
    // Derived combinational signals
    // -------------------------------------------------------------------------
    logic [PRE_W-1:0]    period_last;   // P - 1 for the current speed code
    logic                running;       // a counting mode is active
    logic                step_due;      // the prescaler has reached P - 1
    logic [WIDTH:0]      fib_sum;       // a + b, computed at WIDTH + 1 bits

    assign period_last = (PRE_BASE << speed_reg) - PRE_W'(1);
    assign running     = (state != ST_IDLE);
    assign step_due    = running && (pre == period_last);
    assign fib_sum     = {1'b0, fib_a} + fib_b;

    // -------------------------------------------------------------------------
    // Mode FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        if (stop) begin
            state_nxt = ST_IDLE;
        end else if (start_f) begin
            state_nxt = ST_FIB;
        end else if (start_t) begin
            state_nxt = ST_TMR;
        end
    end

    // -------------------------------------------------------------------------
    // Prescaler and speed register
    // -------------------------------------------------------------------------
    // A command strobe or an update restarts the period. An update therefore
    // delays the next step to P_new cycles after the update edge, even when
    // the old period was about to expire in that same cycle. While idle, the
    // prescaler stays at 0.
    always_comb begin
        speed_nxt = speed_reg;
        pre_nxt   = pre;
        if (stop || start_f || start_t || update || !running) begin
            pre_nxt = '0;
        end else if (step_due) begin
            pre_nxt = '0;
        end else begin
            pre_nxt = pre + PRE_W'(1);
        end
        if (update) begin
            speed_nxt = prog;
        end
    end

    // -------------------------------------------------------------------------
    // Counting datapath
    // -------------------------------------------------------------------------
    always_comb begin
        count_nxt = count_q;
        fib_a_nxt = fib_a;
        fib_b_nxt = fib_b;
        tick_nxt  = 1'b0;
        ovf_nxt   = 1'b0;

        if (stop) begin
            // Hold count. The Fibonacci state is irrelevant until the next
            // start_f reloads it.
        end else if (start_f) begin
            count_nxt = '0;
            fib_a_nxt = '0;
            fib_b_nxt = (WIDTH+1)'(1);
        end else if (start_t) begin
            count_nxt = '0;
        end else if (step_due && !update) begin
            tick_nxt = 1'b1;
            if (state == ST_FIB) begin
                if (fib_b[WIDTH]) begin
                    // The pending value does not fit: restart the sequence.
                    count_nxt = '0;
                    fib_a_nxt = '0;
                    fib_b_nxt = (WIDTH+1)'(1);
                    ovf_nxt   = 1'b1;
                end else begin
                    count_nxt = fib_b[WIDTH-1:0];
                    fib_a_nxt = fib_b[WIDTH-1:0];
                    fib_b_nxt = fib_sum;
                end
            end else begin
                if (count_q == TMAX) begin
                    count_nxt = '0;
                    ovf_nxt   = 1'b1;
                end else begin
                    count_nxt = count_q + WIDTH'(1);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            speed_reg <= '0;
            pre       <= '0;
            fib_a     <= '0;
            fib_b     <= (WIDTH+1)'(1);
            count_q   <= '0;
            tick_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            speed_reg <= speed_nxt;
            pre       <= pre_nxt;
            fib_a     <= fib_a_nxt;
            fib_b     <= fib_b_nxt;
            count_q   <= count_nxt;
            tick_q    <= tick_nxt;
            ovf_q     <= ovf_nxt;
        end
    end

    assign count = count_q;
    assign mode  = state;
    assign tick  = tick_q;
    assign ovf   = ovf_q;

    // -------------------------------------------------------------------------
    // Parity of count. The parity is computed from the next count so that it
    // changes in the same cycle as count.
    // -------------------------------------------------------------------------
`ifdef FIB_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= ^count_nxt;
        end
    end

    assign parity = parity_q;
`else
    assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_fib_timer_gen.sv
// -----------------------------------------------------------------------------
// tb_fib_timer_gen
//
// Directed bench for fib_timer_gen (WIDTH=16, PROG_W=3, DIV_BASE=2,
// TIMER_MAX=19). Expected {ovf, count} pairs are pushed to exp_q when a start
// is driven. They are popped on each tick.
//
// The bench drives inputs 1 time unit after each rising edge. It samples
// outputs at the same time.
// -----------------------------------------------------------------------------
module tb_fib_timer_gen;

  localparam int WIDTH     = 16;
  localparam int PROG_W    = 3;
  localparam int DIV_BASE  = 2;
  localparam int TIMER_MAX = 19;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              update = 1'b0;
  logic [PROG_W-1:0] prog = '0;
  logic              start_f = 1'b0;
  logic              start_t = 1'b0;
  logic              stop = 1'b0;
  logic [WIDTH-1:0]  count;
  logic [1:0]        mode;
  logic              tick;
  logic              ovf;
  logic              parity;

  int n_cmp = 0;
  int n_bad = 0;

  logic [WIDTH:0] exp_q[$];   // {ovf, count}

  fib_timer_gen #(
    .WIDTH(WIDTH), .PROG_W(PROG_W), .DIV_BASE(DIV_BASE), .TIMER_MAX(TIMER_MAX)
  ) dut (
    .clk(clk), .rst(rst), .update(update), .prog(prog),
    .start_f(start_f), .start_t(start_t), .stop(stop),
    .count(count), .mode(mode), .tick(tick), .ovf(ovf), .parity(parity)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_par(input logic [WIDTH-1:0] v);
`ifdef FIB_PARITY_EN
    return ^v;
`else
    return 1'b0;
`endif
  endfunction

  // The k-th Fibonacci tick (k >= 1) from a fresh start. The values are
  // fib(1..L), where fib(L) is the largest Fibonacci number below 2**WIDTH.
  // The next tick is 0 with ovf. After that the pattern repeats.
  function automatic logic [WIDTH:0] fib_exp(input int k);
    longint p, q, t, lim;
    int     cnt, j;
    logic [WIDTH:0] r;
    lim = longint'(1) << WIDTH;
    p = 0; q = 1; cnt = 0;
    while (q < lim) begin
      cnt++; t = p + q; p = q; q = t;
    end
    j = k % (cnt + 1);
    r = '0;
    if (j == 0) begin
      r[WIDTH] = 1'b1;
    end else begin
      p = 0; q = 1;
      for (int i = 1; i < j; i++) begin
        t = p + q; p = q; q = t;
      end
      r[WIDTH-1:0] = WIDTH'(q);
    end
    return r;
  endfunction

  // The k-th timer tick (k >= 1) from a fresh start.
  function automatic logic [WIDTH:0] tmr_exp(input int k);
    int v;
    logic [WIDTH:0] r;
    v = k % (TIMER_MAX + 1);
    r = '0;
    r[WIDTH-1:0] = WIDTH'(v);
    r[WIDTH]     = (v == 0);
    return r;
  endfunction

  task automatic push_fib(input int first, input int n);
    for (int k = first; k < first + n; k++) exp_q.push_back(fib_exp(k));
  endtask

  task automatic push_tmr(input int first, input int n);
    for (int k = first; k < first + n; k++) exp_q.push_back(tmr_exp(k));
  endtask

  // Expect n ticks, spaced exactly `period` cycles, in mode m.
  task automatic expect_ticks(input int n, input int period, input logic [1:0] m);
    logic [WIDTH:0] e;
    for (int k = 0; k < n; k++) begin
      for (int c = 1; c < period; c++) begin
        step_clk();
        check("quiet_tick", tick, 0);
        check("quiet_ovf", ovf, 0);
      end
      step_clk();
      check("tick", tick, 1);
      check("mode_run", mode, m);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = 'x;
      check("count", count, e[WIDTH-1:0]);
      check("ovf", ovf, e[WIDTH]);
      check("parity", parity, exp_par(e[WIDTH-1:0]));
    end
  endtask

  task automatic expect_idle(input int n, input logic [WIDTH-1:0] held);
    for (int c = 0; c < n; c++) begin
      step_clk();
      check("idle_tick", tick, 0);
      check("idle_ovf", ovf, 0);
      check("idle_count", count, held);
      check("idle_mode", mode, 2'b00);
    end
  endtask

  // ---------------- directed sequence ----------------
  logic [WIDTH:0] held_e;

  initial begin
    // Reset
    rst = 1'b0;
    repeat (3) step_clk();
    check("rst_count", count, 0);
    check("rst_mode", mode, 2'b00);
    check("rst_tick", tick, 0);
    check("rst_ovf", ovf, 0);
    check("rst_parity", parity, 0);
    rst = 1'b1;
    expect_idle(3, '0);

    // update prog=3 (P=16), then start_f: 0,1,1,2,3,5,8,13
    update = 1'b1; prog = 3'd3;
    step_clk();
    update = 1'b0;
    check("upd_idle_mode", mode, 2'b00);
    start_f = 1'b1;
    push_fib(1, 7);
    step_clk();
    start_f = 1'b0;
    check("startf_mode", mode, 2'b01);
    check("startf_count", count, 0);
    expect_ticks(7, 16, 2'b01);

    // start_t together with update prog=0 (P=2), 15 ticks, then stop and hold
    start_t = 1'b1; update = 1'b1; prog = 3'd0;
    push_tmr(1, 15);
    step_clk();
    start_t = 1'b0; update = 1'b0;
    check("startt_mode", mode, 2'b10);
    check("startt_count", count, 0);
    expect_ticks(15, 2, 2'b10);
    stop = 1'b1;
    step_clk();
    stop = 1'b0;
    check("stop_mode", mode, 2'b00);
    check("stop_count", count, 15);
    expect_idle(100, 16'd15);

    // Timer wrap 19 -> 0 with ovf
    start_t = 1'b1;
    push_tmr(1, 25);
    step_clk();
    start_t = 1'b0;
    check("wrap_start_count", count, 0);
    expect_ticks(25, 2, 2'b10);

    // update while running: prog=2 (P=8), the next step is 8 cycles later
    update = 1'b1; prog = 3'd2;
    step_clk();
    update = 1'b0;
    check("upd_run_count", count, 5);
    check("upd_run_mode", mode, 2'b10);
    push_tmr(26, 2);
    expect_ticks(2, 8, 2'b10);

    // Fibonacci wrap at 16 bits: 46368 -> 0 with ovf, then 1,1,2
    stop = 1'b1;
    step_clk();
    stop = 1'b0;
    start_f = 1'b1; update = 1'b1; prog = 3'd0;
    push_fib(1, 28);
    step_clk();
    start_f = 1'b0; update = 1'b0;
    check("fibwrap_start_count", count, 0);
    expect_ticks(28, 2, 2'b01);

    // stop + start_f + update(prog=5) in one cycle: stop wins, speed loads
    held_e = fib_exp(28);
    stop = 1'b1; start_f = 1'b1; update = 1'b1; prog = 3'd5;
    step_clk();
    stop = 1'b0; start_f = 1'b0; update = 1'b0;
    check("prio_stop_mode", mode, 2'b00);
    check("prio_stop_count", count, held_e[WIDTH-1:0]);
    expect_idle(4, held_e[WIDTH-1:0]);
    start_f = 1'b1;
    push_fib(1, 1);
    step_clk();
    start_f = 1'b0;
    check("p64_start_mode", mode, 2'b01);
    expect_ticks(1, 64, 2'b01);

    // start_f beats start_t; start_t alone restarts timer mode from a run
    start_f = 1'b1; start_t = 1'b1;
    step_clk();
    start_f = 1'b0; start_t = 1'b0;
    check("prio_f_mode", mode, 2'b01);
    check("prio_f_count", count, 0);
    start_t = 1'b1;
    push_tmr(1, 1);
    step_clk();
    start_t = 1'b0;
    check("restart_t_mode", mode, 2'b10);
    check("restart_t_count", count, 0);
    expect_ticks(1, 64, 2'b10);

    // Run Fibonacci to 21, then reset with a strobe in the same cycle
    start_f = 1'b1; update = 1'b1; prog = 3'd0;
    push_fib(1, 8);
    step_clk();
    start_f = 1'b0; update = 1'b0;
    expect_ticks(8, 2, 2'b01);
    rst = 1'b0; start_t = 1'b1;
    step_clk();
    rst = 1'b1; start_t = 1'b0;
    check("midrst_count", count, 0);
    check("midrst_mode", mode, 2'b00);
    check("midrst_tick", tick, 0);
    check("midrst_ovf", ovf, 0);
    check("midrst_parity", parity, 0);
    expect_idle(5, '0);
    // The speed register returned to 0, so P = 2 again.
    start_f = 1'b1;
    push_fib(1, 3);
    step_clk();
    start_f = 1'b0;
    expect_ticks(3, 2, 2'b01);

    check("exp_q_left", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
